// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, default datapath width and multiply/divide FSM states.
package alu_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/alu_exec_unit_muldiv_seq.sv
// muldiv_seq: iterative signed MULT (shift-add) / DIV (restoring) engine owning HI/LO.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic div_q, div_d, sb_q, sb_d, bz_q, bz_d, done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] p_q, p_d, neg_p, step;
  logic [WIDTH-1:0] abs_a, abs_b, q, r, fix_hi, fix_lo;
  logic [WIDTH:0] madd, rsh, diff;
  logic launch, is_div, sgn;
  always_comb begin
    is_div = op_i == ALU_DIV;
    launch = start_i && (op_i == ALU_MULT || is_div);
    abs_a  = a_i[WIDTH-1] ? -a_i : a_i;
    abs_b  = b_i[WIDTH-1] ? -b_i : b_i;
    // p_q holds {accumulator, multiplier} for MULT and {remainder, dividend/quotient} for DIV
    madd   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    rsh    = p_q[2*WIDTH-1:WIDTH-1];
    diff   = rsh - {1'b0, m_q};
    step   = div_q ? {diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0], p_q[WIDTH-2:0], ~diff[WIDTH]}
                   : {madd, p_q[WIDTH-1:1]};
    neg_p  = -p_q;
    q      = p_q[WIDTH-1:0];
    r      = p_q[2*WIDTH-1:WIDTH];
    sgn    = a_q[WIDTH-1] ^ sb_q;
    fix_hi = bz_q ? a_q : div_q ? (a_q[WIDTH-1] ? -r : r) : (sgn ? neg_p[2*WIDTH-1:WIDTH] : r);
    fix_lo = bz_q ? '1  : div_q ? (sgn ? -q : q)          : (sgn ? neg_p[WIDTH-1:0] : q);
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    a_d     = a_q;
    m_d     = m_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == IDLE && launch) begin
      state_d = RUN;
      cnt_d   = '0;
      div_d   = is_div;
      sb_d    = b_i[WIDTH-1];
      bz_d    = is_div && b_i == '0;
      a_d     = a_i;
      m_d     = is_div ? abs_b : abs_a;
      p_d     = {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
    end else if (state_q == RUN) begin
      p_d     = step;
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == LAST ? FIX : RUN;
    end else if (state_q == FIX) begin
      hi_d    = fix_hi;
      lo_d    = fix_lo;
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      a_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      a_q     <= a_d;
      m_q     <= m_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU; single-cycle ops are combinational, MULT/DIV go to muldiv_seq.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Shamt,
  input  logic             Start,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  logic seq_busy;
  muldiv_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .start_i(Start),
    .op_i   (ALU_Control),
    .a_i    (A),
    .b_i    (B),
    .busy_o (seq_busy),
    .done_o (Done),
    .hi_o   (HI),
    .lo_o   (LO)
  );
  always_comb begin
    Result = '0;
    case (ALU_Control)
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_ADD: Result = A + B;
      ALU_XOR: Result = A ^ B;
      ALU_SUB: Result = A - B;
      ALU_SLT: Result = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      ALU_SLL: Result = B << Shamt;
      ALU_SRL: Result = B >> Shamt;
      ALU_SRA: Result = $signed(B) >>> Shamt;
      ALU_NOR: Result = ~(A | B);
      default: Result = '0;
    endcase
  end
  assign Zero = Result == '0;
  // launching instruction must stall in its own cycle, before the FSM leaves IDLE
  assign Busy = seq_busy || (Start && (ALU_Control == ALU_MULT || ALU_Control == ALU_DIV));
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table-driven single-cycle checks plus directed MULT/DIV sequences.
module tb_alu_exec_unit;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  ALU_Control = 4'b0;
  logic [31:0] A = '0, B = '0;
  logic [4:0]  Shamt = '0;
  logic        Start = 1'b0;
  logic [31:0] Result, HI, LO;
  logic        Zero, Busy, Done;
  int pass_cnt = 0, tot_cnt = 0;

  alu_exec_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .ALU_Control(ALU_Control), .A(A), .B(B),
    .Shamt(Shamt), .Start(Start), .Result(Result), .Zero(Zero), .Busy(Busy),
    .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
  } vec_t;
  vec_t tv[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Launch in the current cycle (cycle 0) and follow the op to its Done pulse.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit inject);
    int n, busy_n;
    ALU_Control = op; A = a; B = b; Start = 1'b1;
    #1;
    chk({name, " busy_c0"}, {31'b0, Busy}, 32'd1);
    busy_n = 1;
    n = 0;
    tick();
    Start = 1'b0;
    n = 1;
    while (!Done && n < 40) begin
      if (Busy) busy_n++;
      if (inject && n == 5) begin
        ALU_Control = 4'b0101; A = 32'd1000; B = 32'd1000; Start = 1'b1;
      end else Start = 1'b0;
      tick();
      n++;
    end
    Start = 1'b0;
    chk({name, " done_cycle"}, n, 32'd34);
    chk({name, " busy_cycles"}, busy_n, 32'd34);
    chk({name, " busy_at_done"}, {31'b0, Busy}, 32'd0);
    chk({name, " hi"}, HI, exp_hi);
    chk({name, " lo"}, LO, exp_lo);
  endtask

  initial begin
    tv[0]  = '{4'b0000, 32'hF0F01234, 32'h0FF0FFFF, 5'd0,  32'h00F01234, 1'b0};
    tv[1]  = '{4'b0001, 32'hF0000000, 32'h0000000F, 5'd0,  32'hF000000F, 1'b0};
    tv[2]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1};
    tv[3]  = '{4'b0010, 32'd7,        32'd8,        5'd0,  32'd15,       1'b0};
    tv[4]  = '{4'b0100, 32'hAAAAAAAA, 32'hFFFF0000, 5'd0,  32'h5555AAAA, 1'b0};
    tv[5]  = '{4'b0101, 32'd3,        32'd4,        5'd0,  32'h00000000, 1'b1};
    tv[6]  = '{4'b0110, 32'd5,        32'd5,        5'd0,  32'h00000000, 1'b1};
    tv[7]  = '{4'b0110, 32'd3,        32'd5,        5'd0,  32'hFFFFFFFE, 1'b0};
    tv[8]  = '{4'b0111, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1'b0};
    tv[9]  = '{4'b0111, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd0,        1'b1};
    tv[10] = '{4'b1000, 32'd0,        32'd1,        5'd31, 32'h80000000, 1'b0};
    tv[11] = '{4'b1001, 32'd0,        32'h80000000, 5'd4,  32'h08000000, 1'b0};
    tv[12] = '{4'b1010, 32'd0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0};
    tv[13] = '{4'b1011, 32'd9,        32'd3,        5'd0,  32'h00000000, 1'b1};
    tv[14] = '{4'b1100, 32'd0,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0};
    tv[15] = '{4'b0011, 32'd1,        32'd2,        5'd0,  32'h00000000, 1'b1};
    tv[16] = '{4'b1111, 32'd1,        32'd2,        5'd0,  32'h00000000, 1'b1};

    tick();
    tick();
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    Reset_n = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      ALU_Control = tv[i].ctl; A = tv[i].a; B = tv[i].b; Shamt = tv[i].sh;
      #1;
      chk($sformatf("vec%0d_result", i), Result, tv[i].res);
      chk($sformatf("vec%0d_zero", i), {31'b0, Zero}, {31'b0, tv[i].z});
      chk($sformatf("vec%0d_busy", i), {31'b0, Busy}, 32'd0);
    end
    tick();

    ALU_Control = 4'b0010; A = 32'd1; B = 32'd1; Start = 1'b1;
    #1;
    chk("nonmd_start_busy", {31'b0, Busy}, 32'd0);
    tick();
    Start = 1'b0;
    #1;
    chk("nonmd_start_idle", {31'b0, Busy}, 32'd0);
    tick();

    run_op("mult_neg3x7", 4'b0101, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
    tick();
    chk("done_pulse_width", {31'b0, Done}, 32'd0);
    run_op("div_neg7by2", 4'b1011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    tick();
    run_op("div_5by0", 4'b1011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0);
    tick();
    run_op("b2b_mult", 4'b0101, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    run_op("b2b_div", 4'b1011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    tick();

    ALU_Control = 4'b0101; A = 32'd6; B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    Reset_n = 1'b0;
    #1;
    chk("midrun_rst_hi", HI, 32'd0);
    chk("midrun_rst_lo", LO, 32'd0);
    chk("midrun_rst_busy", {31'b0, Busy}, 32'd0);
    chk("midrun_rst_done", {31'b0, Done}, 32'd0);
    tick();
    Reset_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (Done || Busy) seen++;
      end
      chk("post_rst_no_done", seen, 32'd0);
    end
    chk("post_rst_lo", LO, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
